// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, code-table geometry and ASCII bounds for the Morse writer.
package morse_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_MARK, S_SPACE, S_CGAP, S_WGAP} state_e;
  localparam int CODE_W = 5;
  localparam int LEN_W = 3;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
endpackage

// File: rtl/morse_code_lut.sv
// morse_code_lut: ASCII to {valid, space, len, code}; code is left-aligned, MSB first, 1 = dash.
module morse_code_lut
  import morse_pkg::*;
(
  input  logic [7:0]        ch_i,
  output logic              valid_o,
  output logic              space_o,
  output logic [LEN_W-1:0]  len_o,
  output logic [CODE_W-1:0] code_o
);
  logic [7:0] up;
  logic [3:0] dig;
  logic is_let, is_dig;
  logic [LEN_W+CODE_W-1:0] ent;
  logic [CODE_W-1:0] dig_code;
  assign up = (ch_i >= ASCII_LA && ch_i <= ASCII_LZ) ? ch_i - (ASCII_LA - ASCII_A) : ch_i;
  assign is_let = up >= ASCII_A && up <= ASCII_Z;
  assign is_dig = ch_i >= ASCII_0 && ch_i <= ASCII_9;
  assign dig = ch_i[3:0];
  // digits 0-5 are dots followed by dashes, 6-9 dashes followed by dots
  assign dig_code = dig <= 4'd5 ? 5'b11111 >> dig : 5'b11111 << (4'd10 - dig);
  always_comb begin
    case (up)
      "A": ent = {3'd2, 5'b01000};
      "B": ent = {3'd4, 5'b10000};
      "C": ent = {3'd4, 5'b10100};
      "D": ent = {3'd3, 5'b10000};
      "E": ent = {3'd1, 5'b00000};
      "F": ent = {3'd4, 5'b00100};
      "G": ent = {3'd3, 5'b11000};
      "H": ent = {3'd4, 5'b00000};
      "I": ent = {3'd2, 5'b00000};
      "J": ent = {3'd4, 5'b01110};
      "K": ent = {3'd3, 5'b10100};
      "L": ent = {3'd4, 5'b01000};
      "M": ent = {3'd2, 5'b11000};
      "N": ent = {3'd2, 5'b10000};
      "O": ent = {3'd3, 5'b11100};
      "P": ent = {3'd4, 5'b01100};
      "Q": ent = {3'd4, 5'b11010};
      "R": ent = {3'd3, 5'b01000};
      "S": ent = {3'd3, 5'b00000};
      "T": ent = {3'd1, 5'b10000};
      "U": ent = {3'd3, 5'b00100};
      "V": ent = {3'd4, 5'b00010};
      "W": ent = {3'd3, 5'b01100};
      "X": ent = {3'd4, 5'b10010};
      "Y": ent = {3'd4, 5'b10110};
      "Z": ent = {3'd4, 5'b11000};
      default: ent = '0;
    endcase
  end
  assign valid_o = is_let || is_dig;
  assign space_o = ch_i == ASCII_SPACE;
  assign len_o = is_dig ? LEN_W'(5) : ent[CODE_W +: LEN_W];
  assign code_o = is_dig ? dig_code : ent[CODE_W-1:0];
endmodule

// File: rtl/morse_text_writer.sv
// morse_text_writer: ASCII valid/ready in, Morse key line out, all timing in whole tick units.
module morse_text_writer
  import morse_pkg::*;
#(
  parameter int DOT_UNITS = 1,
  parameter int DASH_UNITS = 3,
  parameter int SYM_GAP = 1,
  parameter int CHAR_GAP = 3,
  parameter int WORD_GAP = 7,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       tick,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       done_char,
  output logic       err
);
  localparam logic [CNT_W-1:0] T_DOT = CNT_W'(DOT_UNITS);
  localparam logic [CNT_W-1:0] T_DASH = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] T_SYM = CNT_W'(SYM_GAP);
  localparam logic [CNT_W-1:0] T_CGAP = CNT_W'(CHAR_GAP);
  localparam logic [CNT_W-1:0] T_WGAP = CNT_W'(WORD_GAP - CHAR_GAP);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, cnt_step, tgt;
  logic [CODE_W-1:0] sh_q, sh_d, lut_code;
  logic [LEN_W-1:0] len_q, len_d, lut_len;
  logic wsp_q, wsp_d, key_q, key_d, done_q, done_d, err_q, err_d;
  logic lut_valid, lut_space, accept, fin;
  morse_code_lut u_lut (
    .ch_i    (char_data),
    .valid_o (lut_valid),
    .space_o (lut_space),
    .len_o   (lut_len),
    .code_o  (lut_code)
  );
  assign char_ready = en && !reset && state_q == S_IDLE;
  assign accept = char_ready && char_valid;
  assign cnt_inc = cnt_q + 1'b1;
  assign tgt = state_q == S_MARK ? (sh_q[CODE_W-1] ? T_DASH : T_DOT) :
               state_q == S_SPACE ? T_SYM : state_q == S_CGAP ? T_CGAP : T_WGAP;
  assign fin = tick && cnt_inc == tgt;
  assign cnt_step = fin ? '0 : cnt_inc;
  assign key_out = key_q;
  assign busy = state_q != S_IDLE;
  assign done_char = done_q;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    len_d = len_q;
    wsp_d = wsp_q;
    done_d = 1'b0;
    err_d = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: if (accept) begin
          err_d = !lut_valid && !lut_space;
          if (lut_valid || lut_space) begin
            state_d = S_ALIGN;
            sh_d = lut_code;
            len_d = lut_len;
            wsp_d = lut_space;
            cnt_d = '0;
          end
        end
        // ALIGN only resynchronises to the tick grid, so it never counts
        S_ALIGN: if (tick) state_d = wsp_q ? S_WGAP : S_MARK;
        S_MARK: if (tick) begin
          cnt_d = cnt_step;
          if (fin) begin
            sh_d = sh_q << 1;
            len_d = len_q - 1'b1;
            state_d = len_q == LEN_W'(1) ? S_CGAP : S_SPACE;
          end
        end
        S_SPACE: if (tick) begin
          cnt_d = cnt_step;
          if (fin) state_d = S_MARK;
        end
        default: if (tick) begin
          cnt_d = cnt_step;
          if (fin) begin
            state_d = S_IDLE;
            done_d = 1'b1;
          end
        end
      endcase
    end
    key_d = state_d == S_MARK;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      len_q <= '0;
      wsp_q <= 1'b0;
      key_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      len_q <= len_d;
      wsp_q <= wsp_d;
      key_q <= key_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_morse_text_writer.sv
// tb_morse_text_writer: tick-level Morse model with per-cycle compare, directed cases and random traffic.
module tb_morse_text_writer;
  logic clk = 0, reset = 1, en = 1, tick = 0, char_valid = 0;
  logic [7:0] char_data = 0;
  logic char_ready, key_out, busy, done_char, err;
  int nchk = 0, nerr = 0;
  int tper = 4, tph = 0;
  bit rnd_tick = 0;
  int q[$];
  bit exp_key = 0, exp_done = 0, exp_err = 0;
  string LET[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                     "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                     "..-", "...-", ".--", "-..-", "-.--", "--.."};
  string DIG[10] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

  morse_text_writer dut (
    .clk(clk), .reset(reset), .en(en), .tick(tick), .char_valid(char_valid),
    .char_data(char_data), .char_ready(char_ready), .key_out(key_out), .busy(busy),
    .done_char(done_char), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got '%s' expected '%s'", name, act, expv);
    end
  endtask

  // Queue entry per tick consumed after acceptance: 0 key low, 1 key high, 2 character finished.
  task automatic model_push(input logic [7:0] c, output bit ok);
    logic [7:0] u;
    string s;
    ok = 1;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (c == 8'h20) begin
      repeat (7 - 3) q.push_back(0);
      q.push_back(2);
      return;
    end
    if (u >= "A" && u <= "Z") s = LET[u - 8'd65];
    else if (u >= "0" && u <= "9") s = DIG[u - 8'd48];
    else begin
      ok = 0;
      return;
    end
    for (int i = 0; i < s.len(); i++) begin
      repeat (s[i] == 8'h2d ? 3 : 1) q.push_back(1);
      repeat (i == s.len() - 1 ? 3 : 1) q.push_back(0);
    end
    q.push_back(2);
  endtask

  initial forever begin
    logic en_s, tk_s, v_s, r_s;
    logic [7:0] d_s;
    bit ok;
    int e;
    @(posedge clk);
    en_s = en; tk_s = tick; v_s = char_valid; d_s = char_data; r_s = reset;
    #1;
    exp_done = 0;
    exp_err = 0;
    if (r_s) begin
      q.delete();
      exp_key = 0;
    end else if (en_s) begin
      if (q.size() == 0) begin
        if (v_s) begin
          model_push(d_s, ok);
          exp_err = !ok;
        end
      end else if (tk_s) begin
        e = q.pop_front();
        exp_key = (e == 1);
        exp_done = (e == 2);
      end
    end
    chk("key_out", key_out, exp_key);
    chk("done_char", done_char, exp_done);
    chk("err", err, exp_err);
    chk("busy", busy, q.size() != 0);
    chk("char_ready", char_ready, en_s && !r_s && q.size() == 0);
  end

  initial forever begin
    @(negedge clk);
    if (rnd_tick) tick = ($urandom_range(0, 2) == 0);
    else begin
      tick = (tph == tper - 1);
      tph = (tph == tper - 1) ? 0 : tph + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    char_valid = 1;
    char_data = c;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (char_ready) begin
        @(negedge clk);
        char_valid = 0;
        return;
      end
      @(negedge clk);
    end
    char_valid = 0;
    chk("send_timeout", 0, 1);
  endtask

  task automatic measure(output string r);
    int lvl = 1, n = 0;
    bit started = 0;
    r = "";
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (done_char) begin
        if (started) r = {r, $sformatf("%0d", n)};
        return;
      end
      if (!started) begin
        if (key_out) begin
          started = 1;
          n = 1;
          lvl = 1;
        end
      end else if (key_out == lvl) n++;
      else begin
        r = {r, $sformatf("%0d ", n)};
        lvl = key_out;
        n = 1;
      end
    end
    r = {r, "timeout"};
  endtask

  task automatic wait_hi(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (key_out) begin
        ok = 1;
        return;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done_char) begin
        ok = 1;
        return;
      end
    end
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return 8'("A" + $urandom_range(0, 25));
      4, 5: return 8'("a" + $urandom_range(0, 25));
      6, 7: return 8'("0" + $urandom_range(0, 9));
      8: return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    string r;
    int n, hi, dis;
    bit ok, will_acc;
    repeat (3) @(negedge clk);
    chk("rst_key", key_out, 0);
    chk("rst_ready", char_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    #1 chk("ready_after_rst", char_ready, 1);

    send(8'h45);
    measure(r);
    chk_s("E_runs", r, "4 12");
    send("a");
    measure(r);
    chk_s("a_runs", r, "4 4 12 12");
    send("A");
    measure(r);
    chk_s("A_runs", r, "4 4 12 12");

    send("0");
    char_valid = 1;
    char_data = 8'h20;
    measure(r);
    chk_s("zero_runs", r, "12 4 12 4 12 4 12 4 12 12");
    chk("ready_at_done", char_ready, 1);
    n = 0;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) char_valid = 0;
      if (done_char) ok = 1;
    end
    chk("space_done_gap", n, 20);

    send("#");
    chk("hash_err", err, 1);
    chk("hash_busy", busy, 0);
    chk("hash_key", key_out, 0);
    @(posedge clk);
    #1 chk("hash_err_pulse", err, 0);

    send("T");
    wait_hi(ok);
    chk("T_rise", ok, 1);
    hi = 1;
    dis = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (!key_out) break;
      hi++;
      if (hi == 6) begin
        @(negedge clk);
        en = 0;
      end else if (!en) begin
        dis++;
        if (dis == 8) begin
          chk("en_hold_key", key_out, 1);
          @(negedge clk);
          en = 1;
        end
      end
    end
    chk("T_mark_clk", hi, 20);
    wait_done(ok);
    chk("T_done", ok, 1);

    send("O");
    wait_hi(ok);
    chk("O_rise", ok, 1);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_key", key_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", char_ready, 0);
    @(negedge clk);
    reset = 0;
    #1 chk("post_rst_ready", char_ready, 1);

    rnd_tick = 1;
    will_acc = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (will_acc) char_valid = 0;
      if (!char_valid && $urandom_range(0, 2) == 0) begin
        char_valid = 1;
        char_data = pick();
      end
      en = en ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 3) == 0);
      #1 will_acc = char_valid && char_ready;
    end
    @(negedge clk);
    char_valid = 0;
    en = 1;
    for (int i = 0; i < 3000 && busy; i++) @(posedge clk);
    @(posedge clk);
    #2 chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/morse_text_writer.md
# morse_text_writer

Morse transmitter for the alarm text path: the inverse of the ROM-driven text reader, which turns stored Morse into ASCII. It accepts ASCII characters through a valid/ready handshake and drives a single on/off key line (LED/buzzer) with standard Morse timing. All durations are counted in unit ticks supplied by an external `timer_parameter` strobe. It sits between the alarm message source (ROM reader or control FSM) and the alarm indicator output.

## Interface
- `DOT_UNITS`, 1: mark length of a dot, in ticks.
- `DASH_UNITS`, 3: mark length of a dash, in ticks.
- `SYM_GAP`, 1: key-low gap between elements of one character.
- `CHAR_GAP`, 3: key-low gap after every character.
- `WORD_GAP`, 7: total key-low time for a space. Must be greater than `CHAR_GAP`.
- `CNT_W`, 4: width of the unit counter. Must hold the largest unit parameter.

Ports:
- `clk` in, 1: single clock.
- `reset` in, 1: asynchronous, active-high reset.
- `en` in, 1: global enable. Low freezes all state, counters and outputs.
- `tick` in, 1: one-cycle unit-time strobe.
- `char_valid` in, 1: a character is offered.
- `char_data` in, 8: ASCII character.
- `char_ready` out, 1: block can accept a character.
- `key_out` out, 1: Morse key line, 1 = mark.
- `busy` out, 1: the FSM is not in IDLE.
- `done_char` out, 1: one-cycle pulse when a character or space finishes.
- `err` out, 1: one-cycle pulse when an unsupported character is accepted.

## Operation
- Supported characters:
  - `A`–`Z`, with `a`–`z` folded to upper case.
  - `0`–`9`.
  - Space (0x20).
  - Everything else is unsupported.
- Encoding: a code register holds up to 5 elements, MSB first, with 1 = dash. A 3-bit length field runs 1..5.
- FSM states: IDLE, ALIGN, MARK, SPACE, CGAP, WGAP.
- **IDLE**
  - `char_ready` = `en`.
  - On `char_valid & char_ready`:
    - Letter or digit: load the shift register and length, then go to ALIGN.
    - Space: go to ALIGN, tagged as a word gap.
    - Unsupported: pulse `err` next cycle and stay in IDLE.
- **ALIGN**: wait for the first `tick`, then go to MARK (or WGAP for a space). This makes every element an exact number of whole units.
- **MARK**
  - `key_out` = 1.
  - Count ticks up to `DOT_UNITS` or `DASH_UNITS`, chosen by the current MSB.
  - On the final tick, shift the register and decrement the length. Then go to SPACE if elements remain, otherwise CGAP.
- **SPACE**: `key_out` = 0 for `SYM_GAP` ticks, then go to MARK.
- **CGAP**: `key_out` = 0 for `CHAR_GAP` ticks, then go to IDLE and pulse `done_char`.
- **WGAP**: `key_out` = 0 for `WORD_GAP - CHAR_GAP` ticks, then go to IDLE and pulse `done_char`. The preceding character has already supplied `CHAR_GAP`.
- `en` low:
  - `tick` is ignored and the state, counter and `key_out` are held.
  - `char_ready` = 0.
  - Pulses are not generated.
- Reset, including mid-character: immediate IDLE with all outputs 0. The character in progress is lost.
- Reset values: `char_ready` = 0, `key_out` = 0, `busy` = 0, `done_char` = 0, `err` = 0. `char_ready` rises to `en` in the first cycle after reset.

## Timing
- `key_out`, `done_char` and `err` are registered.
- `key_out` rises on the clock edge that samples the first `tick` after acceptance.
- Mark length = units × tick period, exact.
- `char_valid` during busy is not accepted. The source holds `char_data` stable until `char_ready`.
- A `tick` on the same cycle as acceptance is ignored; ALIGN waits for the next tick.
- `done_char` is asserted in the first IDLE cycle. `char_ready` is high in that same cycle, so back-to-back characters lose no clocks.
- `busy` = (state != IDLE).

## Structure
- Shared package `morse_pkg` holds:
  - The state encoding.
  - Constants for the space and ASCII range bounds.
  - The code-table width (5) and length-field width (3).
- Sub-module `morse_code_lut` is a combinational ASCII-to-{valid, len, code} lookup. Case folding happens inside it.
- The FSM, unit counter and shift register live in the top module.

## Test plan
- **'E' (0x45)**, tick every 4 clk: `key_out` high 4 clk, low 12 clk, `done_char` = 1, `err` = 0.
- **'a' (0x61)**, same tick rate: key high 4, low 4, high 12, low 12, then `done_char`. Identical to 'A'.
- **'0' then ' ' back-to-back**:
  - Five 12-clk marks separated by 4-clk gaps, then 12 clk low, then a further 16 clk low.
  - Two `done_char` pulses.
  - `char_ready` is high in the cycle of the first pulse.
- **'#' (0x23)**: accepted, `err` pulses one cycle, `key_out` stays 0, `busy` stays 0.
- **`en` dropped 6 clk into a 'T' dash**: `key_out` is held at 1 and the counter is frozen. On re-enable, the remaining ticks complete the 3-unit mark.
- **`reset` asserted mid-dash of 'O'**: `key_out` = 0 immediately, state IDLE. `char_ready` = 1 in the first cycle after `reset` deasserts.
